// File: rtl/pipe_ctrl_pkg.sv
// Shared types and latencies for the pipeline hazard controller.
// Holds the mult/div latencies, the md state enum and the stall-cause encoding.
package pipe_ctrl_pkg;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 32;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_LOAD_USE = 3'd1,
        CAUSE_MD_STALL = 3'd2,
        CAUSE_BRANCH   = 3'd3,
        CAUSE_FREEZE   = 3'd4
    } cause_t;

    // A frozen pipeline outranks everything; a taken branch squashes the
    // wrong-path ID instruction, so its hazards are irrelevant.
    function automatic cause_t decode_cause(input logic freeze,
                                            input logic branch,
                                            input logic md_stall,
                                            input logic load_use);
        if (freeze)        return CAUSE_FREEZE;
        else if (branch)   return CAUSE_BRANCH;
        else if (md_stall) return CAUSE_MD_STALL;
        else if (load_use) return CAUSE_LOAD_USE;
        else               return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard inputs from the pipeline and the control outputs back to it.
// master drives the hazard inputs (pipeline side); slave is the controller.
interface pipe_ctrl_if;

    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_md_use;
    logic        branch_taken;
    logic        md_start;
    logic        md_op;
    logic        dmem_req;
    logic        dmem_ready;

    logic        pc_wr;
    logic        ifid_wr;
    logic        idex_wr;
    logic        exmem_wr;
    logic        memwb_wr;
    logic        ifid_flush;
    logic        idex_flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_md_use,
               branch_taken, md_start, md_op, dmem_req, dmem_ready,
        input  pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr,
               ifid_flush, idex_flush, md_busy, md_done, stall_cnt, flush_cnt
    );

    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_md_use,
               branch_taken, md_start, md_op, dmem_req, dmem_ready,
        output pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr,
               ifid_flush, idex_flush, md_busy, md_done, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_md_sequencer.sv
// Mult/div occupancy tracker: busy for MUL_LAT or DIV_LAT cycles, done strobe on the last.
// Start is accepted only from idle and not while frozen; the count keeps running through freezes.
module md_sequencer
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic md_op,
    input  logic freeze,
    output logic md_busy,
    output logic md_done
);

    md_state_t  state_q, state_d;
    logic [4:0] md_cnt_q, md_cnt_d;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start && !freeze) begin
                    state_d  = MD_RUN;
                    md_cnt_d = md_op ? 5'(DIV_LAT - 1) : 5'(MUL_LAT - 1);
                end
            end
            MD_RUN: begin
                // md_start here is ignored, including on the done cycle.
                if (md_cnt_q == 5'd0) state_d  = MD_IDLE;
                else                  md_cnt_d = md_cnt_q - 5'd1;
            end
            default: begin
                state_d  = MD_IDLE;
                md_cnt_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = (state_q == MD_RUN);
    assign md_done = md_busy && (md_cnt_q == 5'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: same-cycle stall/flush decode plus md sequencer and perf counters.
// Write enables and flushes are combinational; only the md FSM and counters are registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave ctrl
);

    logic   freeze;
    logic   md_stall;
    logic   load_use;
    logic   md_busy;
    logic   md_done;
    cause_t cause;

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    assign freeze   = ctrl.dmem_req && !ctrl.dmem_ready;
    assign md_stall = md_busy && ctrl.ifid_md_use;
    assign load_use = ctrl.idex_memread && (ctrl.idex_rt != 5'd0) &&
                      ((ctrl.idex_rt == ctrl.ifid_rs) || (ctrl.idex_rt == ctrl.ifid_rt));
    assign cause    = decode_cause(freeze, ctrl.branch_taken, md_stall, load_use);

    md_sequencer u_md_seq (
        .clk      (clk),
        .rst      (rst),
        .md_start (ctrl.md_start),
        .md_op    (ctrl.md_op),
        .freeze   (freeze),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    always_comb begin
        ctrl.pc_wr      = 1'b1;
        ctrl.ifid_wr    = 1'b1;
        ctrl.idex_wr    = 1'b1;
        ctrl.exmem_wr   = 1'b1;
        ctrl.memwb_wr   = 1'b1;
        ctrl.ifid_flush = 1'b0;
        ctrl.idex_flush = 1'b0;
        case (cause)
            CAUSE_FREEZE: begin
                ctrl.pc_wr    = 1'b0;
                ctrl.ifid_wr  = 1'b0;
                ctrl.idex_wr  = 1'b0;
                ctrl.exmem_wr = 1'b0;
                ctrl.memwb_wr = 1'b0;
            end
            CAUSE_BRANCH: begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
            end
            CAUSE_MD_STALL, CAUSE_LOAD_USE: begin
                ctrl.pc_wr      = 1'b0;
                ctrl.ifid_wr    = 1'b0;
                ctrl.idex_flush = 1'b1;
            end
            default: ;
        endcase
        // Reset holds every stage and keeps bubbles flowing into IF/ID and ID/EX.
        if (rst) begin
            ctrl.pc_wr      = 1'b0;
            ctrl.ifid_wr    = 1'b0;
            ctrl.idex_wr    = 1'b0;
            ctrl.exmem_wr   = 1'b0;
            ctrl.memwb_wr   = 1'b0;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((cause == CAUSE_FREEZE || cause == CAUSE_MD_STALL || cause == CAUSE_LOAD_USE) &&
            stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (cause == CAUSE_BRANCH && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctrl.md_busy   = md_busy;
    assign ctrl.md_done   = md_done;
    assign ctrl.stall_cnt = stall_cnt_q;
    assign ctrl.flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: idex_memread  in  1  the EX-stage instruction is a load.
REQ-004 SHALL: idex_rt  in  5  the EX-stage load destination register.
REQ-005 SHALL: ifid_rs, ifid_rt  in  5 each  the ID-stage source registers.
REQ-006 SHALL: ifid_md_use  in  1  the ID-stage instruction is mult, div, mfhi or mflo.
REQ-007 SHALL: branch_taken  in  1  EX resolved a taken branch or jump.
REQ-008 SHALL: md_start  in  1  a mult/div enters EX this cycle; md_op  in  1  (0=mult, 1=div).
REQ-009 SHALL: dmem_req  in  1  MEM stage accesses data memory; dmem_ready  in  1  memory completes this cycle.
REQ-010 SHALL: pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr  out  1 each  pipeline register write enables.
REQ-011 SHALL: ifid_flush, idex_flush  out  1 each  bubble-insert controls.
REQ-012 SHALL: md_busy  out  1  mult/div unit occupied; md_done  out  1  one-cycle HI/LO write strobe.
REQ-013 SHALL: stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-014 SHALL: the block decode one stall cause per cycle, with priority FREEZE > BRANCH > MD_STALL > LOAD_USE > NONE.
REQ-015 SHALL: FREEZE = dmem_req && !dmem_ready; all five write enables 0 and both flushes 0, same cycle (combinational).
REQ-016 SHALL: BRANCH: pc_wr=1, ifid_flush=1, idex_flush=1, other write enables 1; it overrides the stall causes because the ID instruction is wrong-path.
REQ-017 SHALL: MD_STALL = md_busy && ifid_md_use: pc_wr=0, ifid_wr=0, idex_flush=1, and the downstream enables stay 1.
REQ-018 SHALL: LOAD_USE = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt), with outputs identical to MD_STALL.
REQ-019 SHALL: NONE: all write enables 1 and both flushes 0.
REQ-020 SHALL: the mult/div FSM use states MD_IDLE and MD_RUN with a 5-bit down-counter md_cnt.
REQ-021 SHALL: in MD_IDLE, if md_start and not FREEZE, load md_cnt=MUL_LAT-1 (4) or DIV_LAT-1 (31) and go to MD_RUN on the next edge.
REQ-022 SHALL: in MD_RUN, md_cnt decrement every cycle, including FREEZE cycles; when md_cnt==0, md_done=1 for that cycle and the FSM returns to MD_IDLE on the next edge.
REQ-023 SHALL: md_busy=1 exactly while in MD_RUN, so a mult has 5 busy cycles and a div has 32.
REQ-024 SHALL: md_start in MD_RUN be ignored, as the protocol forbids it because MD_STALL holds any md instruction in ID.
REQ-025 SHALL: md_start in the same cycle as md_done (md_cnt==0) be ignored, with no back-to-back chaining.
REQ-026 SHALL: stall_cnt increment by 1 per cycle with cause FREEZE, MD_STALL or LOAD_USE; flush_cnt increment by 1 per BRANCH cycle; both saturate at 16'hFFFF.

Reset
REQ-027 SHALL: while rst=1: pc_wr=ifid_wr=idex_wr=exmem_wr=memwb_wr=0, ifid_flush=idex_flush=1, md_busy=md_done=0.
REQ-028 SHALL: asserting rst put the FSM in MD_IDLE, clear md_cnt to 0 and clear both counters to 0 immediately, including mid-operation (an in-flight div is abandoned with no md_done).
REQ-029 SHALL: on the first edge after rst deasserts, the block operate per REQ-014..026.

Structure
REQ-030 SHALL: MUL_LAT=5, DIV_LAT=32, the md state enum and the stall-cause enum live in shared package pipe_ctrl_pkg.
REQ-031 SHALL: the mult/div FSM and counter be a separate sub-module md_sequencer (in: clk, rst, md_start, md_op, freeze; out: md_busy, md_done).
REQ-032 SHALL: the cause decode be purely combinational; only the md FSM and the performance counters are registered.

Verification
REQ-033 SHALL: Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 -> pc_wr=0, ifid_wr=0, idex_flush=1, stall_cnt +1; with idex_rt=0 -> no stall.
REQ-034 SHALL: Branch plus load-use in the same cycle -> pc_wr=1, ifid_flush=1, idex_flush=1, flush_cnt +1, stall_cnt unchanged.
REQ-035 SHALL: Div: md_start=1, md_op=1 -> md_busy high 32 cycles, md_done on cycle 32; ifid_md_use=1 meanwhile -> 32 stall cycles.
REQ-036 SHALL: Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles during a mult -> all enables 0 for 3 cycles, mult still finishes in 5 cycles.
REQ-037 SHALL: rst pulse at div cycle 10 -> md_busy=0 immediately, no md_done, counters 0, normal operation after release.
REQ-038 SHALL: 70000 consecutive load-use stall cycles -> stall_cnt holds at 16'hFFFF.
